// File: rtl/spi_flash_read_slave_if.sv
// rtl/spi_flash_read_slave_if.sv - AXI4-Lite read-channel bundle between read master and SPI flash read slave
interface spi_flash_read_slave_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output araddr, arprot, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arprot, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/spi_flash_read_slave.sv
// rtl/spi_flash_read_slave.sv - AXI4-Lite read responder fetching one word per access from SPI NOR flash (READ 0x03)
module spi_flash_read_slave #(
    parameter int              ADDR_W     = 24,
    parameter int              DATA_W     = 32,
    parameter int              CLK_DIV    = 2,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = 24'h000600
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    spi_flash_read_slave_if.slave axi,
    output logic                 spi_cs_n,
    output logic                 spi_sclk,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

    localparam int         CMD_BITS   = 8 + ADDR_W;
    localparam int         TOTAL_BITS = CMD_BITS + DATA_W;
    localparam int         BIT_W      = $clog2(TOTAL_BITS + 1);
    localparam int         DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [7:0] READ_CMD   = 8'h03;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [DIV_W-1:0]    div_q;
    logic [BIT_W-1:0]    bit_q;
    logic [CMD_BITS-1:0] tx_q;
    logic [DATA_W-1:0]   rx_q;
    logic                arready_q;
    logic                rvalid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          rresp_q;
    logic                cs_n_q;
    logic                sclk_q;
    logic                mosi_q;

    logic ar_hs;
    logic r_hs;
    logic in_range;
    logic half_end;
    logic shift_done;
    logic unused_arprot;

    assign ar_hs      = axi.arvalid && arready_q;
    assign r_hs       = rvalid_q && axi.rready;
    assign in_range   = axi.araddr < ADDR_LIMIT;
    assign half_end   = (div_q == DIV_W'(CLK_DIV - 1));
    // The access ends at the close of the high phase of the final bit.
    assign shift_done = (state_q == SHIFT) && half_end && sclk_q &&
                        (bit_q == BIT_W'(TOTAL_BITS - 1));
    assign unused_arprot = ^axi.arprot;

    assign axi.arready = arready_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign spi_cs_n    = cs_n_q;
    assign spi_sclk    = sclk_q;
    assign spi_mosi    = mosi_q;

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection: out-of-range addresses skip the flash entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ar_hs) state_d = in_range ? SHIFT : RESP;
            SHIFT:   if (shift_done) state_d = RESP;
            RESP:    if (r_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // SPI shift engine and registered AXI response outputs.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            div_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
        end else begin
            arready_q <= (state_d == IDLE);
            case (state_q)
                IDLE: begin
                    if (ar_hs) begin
                        tx_q  <= {READ_CMD, axi.araddr};
                        div_q <= '0;
                        bit_q <= '0;
                        if (in_range) begin
                            cs_n_q <= 1'b0;
                            mosi_q <= READ_CMD[7];
                        end else begin
                            rvalid_q <= 1'b1;
                            rresp_q  <= 2'b10;
                            rdata_q  <= '0;
                        end
                    end
                end
                SHIFT: begin
                    if (half_end) begin
                        div_q <= '0;
                        if (!sclk_q) begin
                            // Rising edge: MISO is captured here. Samples taken during
                            // the command/address bits are pushed out by the data bits.
                            sclk_q <= 1'b1;
                            rx_q   <= {rx_q[DATA_W-2:0], spi_miso};
                        end else begin
                            sclk_q <= 1'b0;
                            if (shift_done) begin
                                cs_n_q   <= 1'b1;
                                mosi_q   <= 1'b0;
                                rvalid_q <= 1'b1;
                                rresp_q  <= 2'b00;
                                rdata_q  <= rx_q;
                            end else begin
                                // Zero-fill makes MOSI idle low once the address is out.
                                bit_q  <= bit_q + BIT_W'(1);
                                tx_q   <= {tx_q[CMD_BITS-2:0], 1'b0};
                                mosi_q <= tx_q[CMD_BITS-2];
                            end
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                RESP: begin
                    if (r_hs) rvalid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_read_slave.sv
// tb/tb_spi_flash_read_slave.sv - directed self-checking bench for spi_flash_read_slave with a behavioural SPI NOR model
module tb_spi_flash_read_slave;

    logic ACLK   = 1'b0;
    logic ARESET = 1'b1;
    logic spi_cs_n;
    logic spi_sclk;
    logic spi_mosi;
    logic spi_miso = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;

    spi_flash_read_slave_if #(.ADDR_W(24), .DATA_W(32)) axi ();

    spi_flash_read_slave #(
        .ADDR_W    (24),
        .DATA_W    (32),
        .CLK_DIV   (2),
        .ADDR_LIMIT(24'h000600)
    ) dut (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .axi     (axi),
        .spi_cs_n(spi_cs_n),
        .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso)
    );

    always #5 ACLK = ~ACLK;

    function automatic logic [31:0] flash_word(input logic [23:0] a);
        if (a == 24'h00000A) return 32'hDEADBEEF;
        return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'hC3, a[23:16] ^ 8'h96, a[7:0] + 8'h11};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // SPI NOR model: captures command/address on SCLK rise, drives data on SCLK fall.
    int          fl_bits      = 0;
    int          fl_rises     = 0;
    int          mosi_hi_data = 0;
    logic [31:0] fl_cmd       = '0;
    logic [31:0] fl_word      = '0;
    logic        prev_sclk    = 1'b0;
    logic        prev_cs      = 1'b1;

    always @(spi_sclk or spi_cs_n) begin
        if (prev_cs === 1'b1 && spi_cs_n === 1'b0) begin
            fl_bits      = 0;
            fl_rises     = 0;
            mosi_hi_data = 0;
            fl_cmd       = '0;
            spi_miso     = 1'b0;
        end else if (spi_cs_n === 1'b0 && prev_sclk === 1'b0 && spi_sclk === 1'b1) begin
            fl_rises++;
            if (fl_bits < 32) fl_cmd = {fl_cmd[30:0], spi_mosi};
            else if (spi_mosi) mosi_hi_data++;
            fl_bits++;
            if (fl_bits == 32) fl_word = flash_word(fl_cmd[23:0]);
        end else if (spi_cs_n === 1'b0 && prev_sclk === 1'b1 && spi_sclk === 1'b0 &&
                     fl_bits >= 32 && fl_bits < 64) begin
            spi_miso = fl_word[63 - fl_bits];
        end
        prev_sclk = spi_sclk;
        prev_cs   = spi_cs_n;
    end

    // Protocol monitor: AR/R pairing, R stability under backpressure, SCLK only inside CS.
    int          ar_cnt  = 0;
    int          r_cnt   = 0;
    int          viol    = 0;
    logic        prev_rv = 1'b0;
    logic        prev_rr = 1'b0;
    logic [31:0] prev_rd = '0;
    logic [1:0]  prev_rs = '0;

    always @(posedge ACLK) begin
        if (ARESET) begin
            r_cnt = ar_cnt;
        end else begin
            if (axi.arvalid && axi.arready) begin
                if (ar_cnt != r_cnt) viol++;
                ar_cnt++;
            end
            if (axi.rvalid && axi.rready) r_cnt++;
            if (prev_rv && !prev_rr &&
                (!axi.rvalid || axi.rdata !== prev_rd || axi.rresp !== prev_rs)) viol++;
            if (spi_cs_n && spi_sclk) viol++;
        end
        prev_rv = axi.rvalid;
        prev_rr = axi.rready;
        prev_rd = axi.rdata;
        prev_rs = axi.rresp;
    end

    task automatic do_read(input logic [23:0] addr, input int bp, input bit detail);
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        int          exp_lat;
        int          lat;
        int          n;
        int          cs_low;
        int          sclk_hi;
        int          unstable;
        bit          oor;
        oor     = (addr >= 24'h000600);
        exp_d   = oor ? 32'h0 : flash_word(addr);
        exp_r   = oor ? 2'b10 : 2'b00;
        exp_lat = oor ? 1 : 257;
        axi.araddr  = addr;
        axi.arvalid = 1'b1;
        axi.rready  = (bp == 0);
        n = 0;
        while (!axi.arready && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        check("ar_accept", axi.arready, 1'b1);
        @(negedge ACLK);
        axi.arvalid = 1'b0;
        if (detail && !oor) begin
            check("t1_cs_n", spi_cs_n, 1'b0);
            check("t1_arready", axi.arready, 1'b0);
            check("t1_mosi", spi_mosi, 1'b0);
        end
        lat     = 1;
        cs_low  = 0;
        sclk_hi = 0;
        while (!axi.rvalid && lat < 400) begin
            if (!spi_cs_n) cs_low++;
            if (spi_sclk) sclk_hi++;
            if (detail && !oor && lat == 2) check("sclk_low_before_rise", spi_sclk, 1'b0);
            if (detail && !oor && lat == 3) check("first_sclk_rise", spi_sclk, 1'b1);
            @(negedge ACLK);
            lat++;
        end
        check("rvalid_latency", lat, exp_lat);
        check("rdata", axi.rdata, exp_d);
        check("rresp", axi.rresp, exp_r);
        if (oor) begin
            check("oor_cs_low_cycles", cs_low, 0);
            check("oor_sclk_high_cycles", sclk_hi, 0);
        end else begin
            check("mosi_stream", fl_cmd, {8'h03, addr});
            check("sclk_rises", fl_rises, 64);
            if (detail) begin
                check("cs_low_cycles", cs_low, 256);
                check("mosi_zero_in_data", mosi_hi_data, 0);
                check("cs_n_at_resp", spi_cs_n, 1'b1);
                check("sclk_at_resp", spi_sclk, 1'b0);
            end
        end
        unstable = 0;
        for (int i = 0; i < bp; i++) begin
            @(negedge ACLK);
            if (!axi.rvalid || axi.rdata !== exp_d || axi.rresp !== exp_r || axi.arready)
                unstable++;
        end
        if (bp > 0) begin
            check("backpressure_stable", unstable, 0);
            axi.rready = 1'b1;
        end
        @(negedge ACLK);
        axi.rready = 1'b0;
        check("r_done_rvalid", axi.rvalid, 1'b0);
        check("r_done_arready", axi.arready, 1'b1);
    endtask

    initial begin
        int n;
        int r0;
        int a0;
        int v0;
        axi.araddr  = '0;
        axi.arprot  = 3'b000;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;

        ARESET = 1'b1;
        repeat (3) @(negedge ACLK);
        check("rst_arready", axi.arready, 1'b0);
        check("rst_rvalid", axi.rvalid, 1'b0);
        check("rst_rdata", axi.rdata, 32'h0);
        check("rst_rresp", axi.rresp, 2'b00);
        check("rst_cs_n", spi_cs_n, 1'b1);
        check("rst_sclk", spi_sclk, 1'b0);
        check("rst_mosi", spi_mosi, 1'b0);
        ARESET = 1'b0;
        @(negedge ACLK);
        check("arready_after_reset", axi.arready, 1'b1);

        do_read(24'h00000A, 0, 1'b1);
        check("rdata_deadbeef", axi.rdata, 32'hDEADBEEF);
        do_read(24'h0005FF, 10, 1'b1);
        do_read(24'h000600, 0, 1'b1);
        do_read(24'hFFFFFF, 3, 1'b1);

        for (int a = 0; a <= 24'h000500; a += 10) do_read(24'(a), 0, 1'b0);
        do_read(24'h000000, 0, 1'b0);

        axi.araddr  = 24'h000100;
        axi.arvalid = 1'b1;
        axi.rready  = 1'b1;
        n = 0;
        while (!axi.arready && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        @(negedge ACLK);
        axi.arvalid = 1'b0;
        repeat (80) @(negedge ACLK);
        check("mid_shift_cs_n", spi_cs_n, 1'b0);
        ARESET = 1'b1;
        @(negedge ACLK);
        check("midrst_cs_n", spi_cs_n, 1'b1);
        check("midrst_sclk", spi_sclk, 1'b0);
        check("midrst_arready", axi.arready, 1'b0);
        check("midrst_rvalid", axi.rvalid, 1'b0);
        ARESET = 1'b0;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge ACLK);
            if (axi.rvalid) n++;
        end
        check("no_rvalid_after_reset", n, 0);
        axi.rready = 1'b0;
        do_read(24'h000014, 0, 1'b1);

        r0 = r_cnt;
        a0 = ar_cnt;
        v0 = viol;
        axi.araddr  = 24'h000030;
        axi.arvalid = 1'b1;
        axi.rready  = 1'b1;
        n = 0;
        while ((r_cnt - r0) < 3 && n < 1200) begin
            @(negedge ACLK);
            n++;
        end
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        check("busy_r_handshakes", r_cnt - r0, 3);
        check("busy_ar_handshakes", ar_cnt - a0, 3);
        check("busy_protocol", viol - v0, 0);
        repeat (3) @(negedge ACLK);

        check("protocol_violations", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
